// File: rtl/sram_arbiter.sv
// Round-robin arbiter between the CPU port (A) and the LCD frame-fetch DMA port (B) in front of
// the 256K x 16 asynchronous SRAM, sequencing the SRAM strobes with a fixed access length.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int AW            = 18,
  parameter int DW            = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  output logic          a_ack,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata,
  output logic          b_ack,
  output logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_din,
  output logic [DW-1:0] sram_dout,
  output logic          sram_dout_en,
  output logic          sram_cen,
  output logic          sram_oen,
  output logic          sram_wen
);

  localparam int CW = $clog2(ACCESS_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gntB_q, gntB_d;
  logic          lastB_q, lastB_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          doutEn_q, doutEn_d;
  logic          cen_q, cen_d;
  logic          oen_q, oen_d;
  logic          wen_q, wen_d;
  logic          aAck_q, aAck_d;
  logic          bAck_q, bAck_d;
  logic [DW-1:0] aRdata_q, aRdata_d;
  logic [DW-1:0] bRdata_q, bRdata_d;
  logic          pickB;
  logic          inAccess;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gntB_q   <= 1'b0;
      lastB_q  <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      doutEn_q <= 1'b0;
      cen_q    <= 1'b1;
      oen_q    <= 1'b1;
      wen_q    <= 1'b1;
      aAck_q   <= 1'b0;
      bAck_q   <= 1'b0;
      aRdata_q <= '0;
      bRdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gntB_q   <= gntB_d;
      lastB_q  <= lastB_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      doutEn_q <= doutEn_d;
      cen_q    <= cen_d;
      oen_q    <= oen_d;
      wen_q    <= wen_d;
      aAck_q   <= aAck_d;
      bAck_q   <= bAck_d;
      aRdata_q <= aRdata_d;
      bRdata_q <= bRdata_d;
    end
  end

  // Outputs are registered, so the strobes computed here belong to the state being entered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gntB_d   = gntB_q;
    lastB_d  = lastB_q;
    we_d     = we_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    doutEn_d = 1'b0;
    cen_d    = 1'b1;
    oen_d    = 1'b1;
    wen_d    = 1'b1;
    aAck_d   = 1'b0;
    bAck_d   = 1'b0;
    aRdata_d = aRdata_q;
    bRdata_d = bRdata_q;
    pickB    = 1'b0;
    inAccess = 1'b0;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          pickB    = b_req && (!a_req || !lastB_q);
          gntB_d   = pickB;
          lastB_d  = pickB;
          we_d     = pickB ? b_we    : a_we;
          addr_d   = pickB ? b_addr  : a_addr;
          dout_d   = pickB ? b_wdata : a_wdata;
          cnt_d    = '0;
          state_d  = ACCESS;
          inAccess = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == LAST) begin
          state_d = ACK;
          aAck_d  = !gntB_q;
          bAck_d  = gntB_q;
          if (!we_q) begin
            if (gntB_q) bRdata_d = sram_din;
            else        aRdata_d = sram_din;
          end
        end else begin
          cnt_d    = cnt_q + CW'(1);
          inAccess = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // wen rises on the final access cycle so write data is still driven past its rising edge.
    if (inAccess) begin
      cen_d = 1'b0;
      if (we_d) begin
        doutEn_d = 1'b1;
        wen_d    = (cnt_d == LAST);
      end else begin
        oen_d = 1'b0;
      end
    end
  end

  assign sram_addr    = addr_q;
  assign sram_dout    = dout_q;
  assign sram_dout_en = doutEn_q;
  assign sram_cen     = cen_q;
  assign sram_oen     = oen_q;
  assign sram_wen     = wen_q;
  assign a_ack        = aAck_q;
  assign b_ack        = bAck_q;
  assign a_rdata      = aRdata_q;
  assign b_rdata      = bRdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: two instances (2- and 4-cycle accesses) share one stimulus, a pin-level
// SRAM model answers the observed instance, and a transaction-level memory predicts read data.
module tb_sram_arbiter;

  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          aReq = 1'b0, aWe = 1'b0, bReq = 1'b0, bWe = 1'b0;
  logic [AW-1:0] aAddr = '0, bAddr = '0;
  logic [DW-1:0] aWdata = '0, bWdata = '0;
  logic [DW-1:0] sramDin = '0;

  logic [DW-1:0] aRdata [2];
  logic [DW-1:0] bRdata [2];
  logic [DW-1:0] sramDout [2];
  logic [AW-1:0] sramAddr [2];
  logic          aAck [2];
  logic          bAck [2];
  logic          doutEn [2];
  logic          cen [2];
  logic          oen [2];
  logic          wen [2];

  int   sel = 0;
  int   checks = 0;
  int   errors = 0;
  int   tbLast = 1;
  logic prevWen = 1'b1;

  logic [DW-1:0] refMem [logic [AW-1:0]];
  logic [DW-1:0] pinMem [logic [AW-1:0]];
  logic [AW-1:0] pool [6] = '{18'h00010, 18'h00020, 18'h3FFFF, 18'h00000, 18'h12345, 18'h2AAAA};

  always #5 clk = ~clk;

  sram_arbiter #(.ACCESS_CYCLES(2), .AW(AW), .DW(DW)) dut2 (
    .clk(clk), .reset(reset),
    .a_req(aReq), .a_we(aWe), .a_addr(aAddr), .a_wdata(aWdata), .a_rdata(aRdata[0]), .a_ack(aAck[0]),
    .b_req(bReq), .b_we(bWe), .b_addr(bAddr), .b_wdata(bWdata), .b_rdata(bRdata[0]), .b_ack(bAck[0]),
    .sram_addr(sramAddr[0]), .sram_din(sramDin), .sram_dout(sramDout[0]), .sram_dout_en(doutEn[0]),
    .sram_cen(cen[0]), .sram_oen(oen[0]), .sram_wen(wen[0])
  );

  sram_arbiter #(.ACCESS_CYCLES(4), .AW(AW), .DW(DW)) dut4 (
    .clk(clk), .reset(reset),
    .a_req(aReq), .a_we(aWe), .a_addr(aAddr), .a_wdata(aWdata), .a_rdata(aRdata[1]), .a_ack(aAck[1]),
    .b_req(bReq), .b_we(bWe), .b_addr(bAddr), .b_wdata(bWdata), .b_rdata(bRdata[1]), .b_ack(bAck[1]),
    .sram_addr(sramAddr[1]), .sram_din(sramDin), .sram_dout(sramDout[1]), .sram_dout_en(doutEn[1]),
    .sram_cen(cen[1]), .sram_oen(oen[1]), .sram_wen(wen[1])
  );

  // Unwritten locations read back as a fixed scramble of their address.
  function automatic logic [DW-1:0] fetch(input bit pinSide, input logic [AW-1:0] a);
    logic [DW-1:0] dflt;
    dflt = a[15:0] ^ 16'hC3A5;
    if (pinSide) return pinMem.exists(a) ? pinMem[a] : dflt;
    return refMem.exists(a) ? refMem[a] : dflt;
  endfunction

  // Asynchronous SRAM: a write lands on the rising edge of wen while cen is low.
  always @(negedge clk) begin
    if (wen[sel] && !prevWen && !cen[sel]) pinMem[sramAddr[sel]] = sramDout[sel];
    prevWen = wen[sel];
    sramDin = (!cen[sel] && !oen[sel]) ? fetch(1'b1, sramAddr[sel]) : '0;
  end

  function automatic int acOf(input int s);
    return (s == 0) ? 2 : 4;
  endfunction

  function automatic logic ackOf(input int port);
    return (port == 0) ? aAck[sel] : bAck[sel];
  endfunction

  function automatic logic [DW-1:0] rdOf(input int port);
    return (port == 0) ? aRdata[sel] : bRdata[sel];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (port == 0) begin aReq = req; aWe = we; aAddr = addr; aWdata = data; end
    else           begin bReq = req; bWe = we; bAddr = addr; bWdata = data; end
  endtask

  task automatic setReq(input int port, input logic req);
    if (port == 0) aReq = req;
    else           bReq = req;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    aReq  = 1'b0;
    bReq  = 1'b0;
    tick();
    tick();
    reset  = 1'b0;
    tbLast = 1;
  endtask

  // One access on a single port, observed cycle by cycle and judged against the access rules.
  task automatic applyStimulus(input int port, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input bit dropAfter, input bit mutate,
                               input bit pulseOther);
    int ac, cenLow, oenLow, wenLow, enHigh, ackCyc, ownAcks, otherAcks, addrBad, doutBad;
    logic reqNow;
    logic [DW-1:0] ownBefore, otherBefore, expRd, rdAtAck;
    ac = acOf(sel);
    cenLow = 0; oenLow = 0; wenLow = 0; enHigh = 0; ackCyc = -1;
    ownAcks = 0; otherAcks = 0; addrBad = 0; doutBad = 0; rdAtAck = '0;
    ownBefore   = rdOf(port);
    otherBefore = rdOf(1 - port);
    expRd       = we ? ownBefore : fetch(1'b0, addr);
    reqNow      = 1'b1;
    drive(port, 1'b1, we, addr, data);
    for (int k = 1; k <= ac + 2; k++) begin
      tick();
      if (!cen[sel]) begin
        cenLow++;
        if (sramAddr[sel] !== addr) addrBad++;
      end
      if (!oen[sel]) oenLow++;
      if (!wen[sel]) wenLow++;
      if (doutEn[sel]) begin
        enHigh++;
        if (sramDout[sel] !== data) doutBad++;
      end
      if (ackOf(1 - port)) otherAcks++;
      if (ackOf(port)) begin
        ownAcks++;
        if (ackCyc < 0) begin ackCyc = k; rdAtAck = rdOf(port); end
        reqNow = 1'b0;
      end
      if (k == 1 && dropAfter) reqNow = 1'b0;
      if (k == 1 && mutate) drive(port, reqNow, ~we, addr ^ 18'h00030, ~data);
      else setReq(port, reqNow);
      if (pulseOther) setReq(1 - port, k == 1);
    end
    setReq(port, 1'b0);
    setReq(1 - port, 1'b0);
    checkOutput("cen_low_cycles", cenLow, ac);
    checkOutput("oen_low_cycles", oenLow, we ? 0 : ac);
    checkOutput("wen_low_cycles", wenLow, we ? ac - 1 : 0);
    checkOutput("dout_en_cycles", enHigh, we ? ac : 0);
    checkOutput("addr_during_access", addrBad, 0);
    checkOutput("dout_during_write", doutBad, 0);
    checkOutput("ack_cycle", ackCyc, ac + 1);
    checkOutput("ack_pulses", ownAcks, 1);
    checkOutput("other_port_ack", otherAcks, 0);
    checkOutput("rdata_at_ack", rdAtAck, expRd);
    checkOutput("rdata_held", rdOf(port), expRd);
    checkOutput("other_rdata_kept", rdOf(1 - port), otherBefore);
    if (we) begin
      refMem[addr] = data;
      checkOutput("sram_content", fetch(1'b1, addr), data);
    end
  endtask

  // Both ports read continuously; grants must alternate starting from the port after tbLast.
  task automatic applyTieStimulus(input int grants);
    int ac, acks, lastAckCyc, gntPort, expPort;
    logic prevCen;
    ac = acOf(sel);
    acks = 0; lastAckCyc = -1; prevCen = 1'b1;
    drive(0, 1'b1, 1'b0, 18'h00100, 16'h0000);
    drive(1, 1'b1, 1'b0, 18'h00200, 16'h0000);
    for (int cyc = 1; cyc <= grants * (ac + 2) + 4 && acks < grants; cyc++) begin
      tick();
      if (prevCen && !cen[sel]) begin
        expPort = (tbLast == 1) ? 0 : 1;
        tbLast  = expPort;
        gntPort = (sramAddr[sel] == 18'h00100) ? 0 : (sramAddr[sel] == 18'h00200) ? 1 : 2;
        checkOutput("tie_grant_port", gntPort, expPort);
      end
      prevCen = cen[sel];
      if (aAck[sel] || bAck[sel]) begin
        checkOutput("tie_ack_port", {aAck[sel], bAck[sel]}, (tbLast == 0) ? 2'b10 : 2'b01);
        if (lastAckCyc >= 0) checkOutput("tie_ack_spacing", cyc - lastAckCyc, ac + 2);
        checkOutput("tie_rdata", (tbLast == 0) ? aRdata[sel] : bRdata[sel],
                    fetch(1'b0, (tbLast == 0) ? 18'h00100 : 18'h00200));
        lastAckCyc = cyc;
        acks++;
      end
    end
    aReq = 1'b0;
    bReq = 1'b0;
    checkOutput("tie_ack_count", acks, grants);
    for (int i = 0; i < ac + 2; i++) tick();
  endtask

  initial begin
    resetDut();
    for (int s = 0; s < 2; s++) begin
      checkOutput("reset_cen", cen[s], 1'b1);
      checkOutput("reset_oen", oen[s], 1'b1);
      checkOutput("reset_wen", wen[s], 1'b1);
      checkOutput("reset_dout_en", doutEn[s], 1'b0);
      checkOutput("reset_addr", sramAddr[s], 18'h0);
      checkOutput("reset_dout", sramDout[s], 16'h0);
      checkOutput("reset_acks", {aAck[s], bAck[s]}, 2'b00);
      checkOutput("reset_a_rdata", aRdata[s], 16'h0);
      checkOutput("reset_b_rdata", bRdata[s], 16'h0);
    end

    sel = 0;
    applyStimulus(0, 1'b1, 18'h00010, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 18'h00010, 16'h0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 18'h00010, 16'h0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(1, 1'b1, 18'h3FFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus($urandom_range(0, 1), 1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)],
                    DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    end

    resetDut();
    applyTieStimulus(6);

    // Reset lands in the second cycle of a tie-won write; the lost access must not shift the rotation.
    resetDut();
    drive(0, 1'b1, 1'b1, 18'h00300, 16'h1234);
    drive(1, 1'b1, 1'b0, 18'h00200, 16'h0000);
    tick();
    checkOutput("pre_reset_grant", sramAddr[sel], 18'h00300);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("midreset_cen", cen[sel], 1'b1);
    checkOutput("midreset_wen", wen[sel], 1'b1);
    checkOutput("midreset_oen", oen[sel], 1'b1);
    checkOutput("midreset_dout_en", doutEn[sel], 1'b0);
    checkOutput("midreset_acks", {aAck[sel], bAck[sel]}, 2'b00);
    tick();
    reset  = 1'b0;
    tbLast = 1;
    applyTieStimulus(4);

    reset = 1'b1;
    sel   = 1;
    resetDut();
    applyStimulus(1, 1'b1, 18'h3FFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 18'h3FFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus($urandom_range(0, 1), 1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)],
                    DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
    end
    resetDut();
    applyTieStimulus(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
